// File: rtl/x3_serial_bcd_adder.sv
// x3_serial_bcd_adder: digit-serial excess-3 adder, one XS-3 digit per clock,
// LSB digit first, with a start/busy/done handshake and out-of-range digit flag.
// Optional subtract mode is compiled in when X3_SUB_EN is defined; otherwise
// the sub port is accepted but has no effect.
module x3_serial_bcd_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, res_q, res_nxt;
  logic            c_q, c_nxt;
  logic            inv_q;
  logic [IW-1:0]   idx_q;
  logic            last_digit;
  logic [W-1:0]    b_in;
  logic            c_in;
  logic            inv_in;
  logic [4:0]      s5;
  logic [3:0]      digit;

  // Operand conditioning at accept: nines' complement of B and forced carry in subtract mode
`ifdef X3_SUB_EN
  always_comb begin
    b_in = sub ? ~b : b;
    c_in = sub ? 1'b1 : cin;
  end
`else
  logic sub_unused;
  assign sub_unused = sub;
  always_comb begin
    b_in = b;
    c_in = cin;
  end
`endif

  // Range check on the raw operand digits (B checked before any complementing)
  always_comb begin
    inv_in = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] < 4'b0011 || a[4*i +: 4] > 4'b1100) inv_in = 1'b1;
      if (b[4*i +: 4] < 4'b0011 || b[4*i +: 4] > 4'b1100) inv_in = 1'b1;
    end
  end

  // One XS-3 digit step on the current low digits; result digit enters from the top
  always_comb begin
    s5 = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, c_q};
    if (s5[4]) begin
      digit = s5[3:0] + 4'd3;
      c_nxt = 1'b1;
    end else begin
      digit = s5[3:0] - 4'd3;
      c_nxt = 1'b0;
    end
    // shift form keeps DIGITS=1 legal (no zero-width slice of res_q)
    res_nxt = (res_q >> 4) | (W'(digit) << (W - 4));
  end

  assign last_digit = (idx_q == IW'(DIGITS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_digit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Datapath: latch operands on accept, shift digits during RUN, publish results entering DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      inv_q   <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b_in;
            c_q   <= c_in;
            inv_q <= inv_in;
            idx_q <= '0;
            res_q <= '0;
          end
        end
        S_RUN: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          c_q   <= c_nxt;
          res_q <= res_nxt;
          idx_q <= idx_q + 1'b1;
          if (last_digit) begin
            sum     <= res_nxt;
            cout    <= c_nxt;
            invalid <= inv_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x3_serial_bcd_adder.sv
// Self-checking bench for x3_serial_bcd_adder at DIGITS=1, 2 and 8.
// Expected results come from a decimal digit-by-digit reference model.
module tb_x3_serial_bcd_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [31:0] sum_v [3];
  logic [2:0]  start_v = '0;
  logic [2:0]  cin_v = '0;
  logic [2:0]  sub_v = '0;
  logic [2:0]  cout_v, inv_v, busy_v, done_v;

  logic [3:0]  s1;
  logic [7:0]  s2;
  logic [31:0] s8;
  logic co1, co2, co8, iv1, iv2, iv8, bz1, bz2, bz8, dn1, dn2, dn8;

  int total = 0;
  int bad = 0;

  x3_serial_bcd_adder #(.DIGITS(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][3:0]), .b(b_v[0][3:0]),
    .cin(cin_v[0]), .sub(sub_v[0]), .sum(s1), .cout(co1), .invalid(iv1),
    .busy(bz1), .done(dn1));

  x3_serial_bcd_adder #(.DIGITS(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
    .cin(cin_v[1]), .sub(sub_v[1]), .sum(s2), .cout(co2), .invalid(iv2),
    .busy(bz2), .done(dn2));

  x3_serial_bcd_adder #(.DIGITS(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .cin(cin_v[2]), .sub(sub_v[2]), .sum(s8), .cout(co8), .invalid(iv8),
    .busy(bz8), .done(dn8));

  assign sum_v[0] = 32'(s1);
  assign sum_v[1] = 32'(s2);
  assign sum_v[2] = s8;
  assign cout_v = {co8, co2, co1};
  assign inv_v  = {iv8, iv2, iv1};
  assign busy_v = {bz8, bz2, bz1};
  assign done_v = {dn8, dn2, dn1};

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        i;
  } exp_t;

  function automatic int ndig(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 8);
  endfunction

  // Decimal reference: each XS-3 digit d stands for value d-3; a column carries at >= 10.
  function automatic exp_t model(input int nd, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t r;
    int c, x, y, v;
    logic [3:0] da, db;
    logic sb;
`ifdef X3_SUB_EN
    sb = sub;
`else
    sb = 1'b0;
`endif
    c = sb ? 1 : int'(cin);
    r.s = '0;
    r.i = 1'b0;
    for (int i = 0; i < nd; i++) begin
      da = a[4*i +: 4];
      db = b[4*i +: 4];
      if (da < 4'd3 || da > 4'd12 || db < 4'd3 || db > 4'd12) r.i = 1'b1;
      x = int'(da) - 3;
      y = int'(db) - 3;
      if (sb) y = 9 - y;
      v = x + y + c;
      if (v >= 10) begin
        v = v - 10;
        c = 1;
      end else begin
        c = 0;
      end
      r.s[4*i +: 4] = 4'((v + 3) & 15);
    end
    r.c = (c != 0);
    return r;
  endfunction

  function automatic logic [31:0] rand_operand(input int nd);
    logic [31:0] v;
    int r;
    v = '0;
    for (int i = 0; i < nd; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, 5);
        v[4*i +: 4] = 4'((r < 3) ? r : r + 10);
      end else begin
        v[4*i +: 4] = 4'($urandom_range(3, 12));
      end
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation on DUT k and wait for done; lat = edges from accept to done, -1 on timeout
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, output int lat);
    a_v[k] = a;
    b_v[k] = b;
    cin_v[k] = cin;
    sub_v[k] = sub;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    lat = 1;
    while (!done_v[k] && lat < 40) begin
      tick();
      lat++;
    end
    if (!done_v[k]) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_v = '0;
    for (int k = 0; k < 3; k++) begin
      a_v[k] = '0;
      b_v[k] = '0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({sum_v[k], cout_v[k], inv_v[k], busy_v[k], done_v[k]} !== 36'd0) begin
        bad++;
        $display("FAIL reset_state dut%0d: got sum=%h cout=%b inv=%b busy=%b done=%b want all zero",
                 k, sum_v[k], cout_v[k], inv_v[k], busy_v[k], done_v[k]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_examples();
    int lat;
    run_op(1, 32'h9C, 32'h68, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL add69_35_latency: got %0d want 3", lat); end
    total++;
    if ({sum_v[1], cout_v[1], inv_v[1]} !== {32'h37, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL add69_35: got sum=%h cout=%b inv=%b want sum=37 cout=1 inv=0",
               sum_v[1], cout_v[1], inv_v[1]);
    end
    tick();
    total++;
    if ({busy_v[1], done_v[1]} !== 2'b00) begin
      bad++;
      $display("FAIL done_one_cycle: got busy=%b done=%b want 0 0", busy_v[1], done_v[1]);
    end
    run_op(1, 32'hCC, 32'hCC, 1'b1, 1'b0, lat);
    total++;
    if ({sum_v[1], cout_v[1], inv_v[1]} !== {32'hCC, 1'b1, 1'b0} || lat !== 3) begin
      bad++;
      $display("FAIL add99_99_1: got sum=%h cout=%b inv=%b lat=%0d want sum=cc cout=1 inv=0 lat=3",
               sum_v[1], cout_v[1], inv_v[1], lat);
    end
    a_v[1] = 32'h33;
    b_v[1] = 32'h44;
    cin_v[1] = 1'b0;
    repeat (3) tick();
    total++;
    if ({sum_v[1], cout_v[1], done_v[1]} !== {32'hCC, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL result_hold: got sum=%h cout=%b done=%b want sum=cc cout=1 done=0",
               sum_v[1], cout_v[1], done_v[1]);
    end
  endtask

  task automatic test_invalid_busy_start();
    exp_t e;
    int dones;
    e = model(2, 32'h03, 32'h33, 1'b0, 1'b0);
    a_v[1] = 32'h03;
    b_v[1] = 32'h33;
    cin_v[1] = 1'b0;
    sub_v[1] = 1'b0;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    tick();
    start_v[1] = 1'b1;
    tick();
    total++;
    if ({done_v[1], sum_v[1], cout_v[1], inv_v[1]} !== {1'b1, e.s, e.c, 1'b1}) begin
      bad++;
      $display("FAIL invalid_flag: got done=%b sum=%h cout=%b inv=%b want done=1 sum=%h cout=%b inv=1",
               done_v[1], sum_v[1], cout_v[1], inv_v[1], e.s, e.c);
    end
    tick();
    start_v[1] = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_v[1] || busy_v[1]) dones++;
      tick();
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL busy_start_ignored: got %0d busy/done cycles after done want 0", dones);
    end
  endtask

  task automatic test_reset_midop();
    int dones;
    a_v[1] = 32'h5A;
    b_v[1] = 32'h77;
    cin_v[1] = 1'b0;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    total++;
    if ({busy_v[1], done_v[1], sum_v[1], cout_v[1], inv_v[1]} !== 36'd0) begin
      bad++;
      $display("FAIL reset_midop: got busy=%b done=%b sum=%h cout=%b inv=%b want all zero",
               busy_v[1], done_v[1], sum_v[1], cout_v[1], inv_v[1]);
    end
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_v[1]) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL reset_midop_no_done: got %0d done pulses want 0", dones);
    end
  endtask

  task automatic test_sub();
    int lat;
    logic [31:0] want1, want2;
    logic wc1, wc2;
`ifdef X3_SUB_EN
    want1 = 32'h4B; wc1 = 1'b1;
    want2 = 32'hB5; wc2 = 1'b0;
`else
    want1 = 32'hA5; wc1 = 1'b0;
    want2 = 32'hA5; wc2 = 1'b0;
`endif
    run_op(1, 32'h78, 32'h5A, 1'b0, 1'b1, lat);
    total++;
    if ({sum_v[1], cout_v[1]} !== {want1, wc1} || lat !== 3) begin
      bad++;
      $display("FAIL sub45_27: got sum=%h cout=%b lat=%0d want sum=%h cout=%b lat=3",
               sum_v[1], cout_v[1], lat, want1, wc1);
    end
    tick();
    run_op(1, 32'h5A, 32'h78, 1'b0, 1'b1, lat);
    total++;
    if ({sum_v[1], cout_v[1]} !== {want2, wc2} || lat !== 3) begin
      bad++;
      $display("FAIL sub27_45: got sum=%h cout=%b lat=%0d want sum=%h cout=%b lat=3",
               sum_v[1], cout_v[1], lat, want2, wc2);
    end
    tick();
  endtask

  // start held high: each accept in the first idle cycle after DONE; inputs scrambled every cycle
  task automatic test_back_to_back(input int k);
    exp_t q[$];
    exp_t e;
    int nd, t, last, ndone, acc, limit;
    nd = ndig(k);
    t = 0;
    last = -1;
    ndone = 0;
    acc = 0;
    limit = 12 * (nd + 2) + 20;
    a_v[k] = rand_operand(nd);
    b_v[k] = rand_operand(nd);
    cin_v[k] = 1'($urandom);
    sub_v[k] = 1'($urandom);
    start_v[k] = 1'b1;
    while (ndone < 12 && t < limit) begin
      if (!busy_v[k] && start_v[k]) begin
        q.push_back(model(nd, a_v[k], b_v[k], cin_v[k], sub_v[k]));
        acc++;
      end
      tick();
      t++;
      if (acc >= 12) start_v[k] = 1'b0;
      if (done_v[k]) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_d%0d_extra_done: got done at t=%0d want no pending op", nd, t);
        end else begin
          e = q.pop_front();
          if ({sum_v[k], cout_v[k], inv_v[k]} !== {e.s, e.c, e.i}) begin
            bad++;
            $display("FAIL b2b_d%0d_result: got sum=%h cout=%b inv=%b want sum=%h cout=%b inv=%b",
                     nd, sum_v[k], cout_v[k], inv_v[k], e.s, e.c, e.i);
          end
        end
        if (last >= 0) begin
          total++;
          if (t - last !== nd + 2) begin
            bad++;
            $display("FAIL b2b_d%0d_spacing: got %0d want %0d", nd, t - last, nd + 2);
          end
        end
        last = t;
        ndone++;
      end
      a_v[k] = rand_operand(nd);
      b_v[k] = rand_operand(nd);
      cin_v[k] = 1'($urandom);
      sub_v[k] = 1'($urandom);
    end
    start_v[k] = 1'b0;
    total++;
    if (ndone !== 12) begin
      bad++;
      $display("FAIL b2b_d%0d_count: got %0d done pulses want 12", nd, ndone);
    end
    repeat (nd + 3) tick();
  endtask

  initial begin
    test_reset();
    test_add_examples();
    test_invalid_busy_start();
    test_reset_midop();
    test_sub();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
